// File: rtl/pkt_buffer.sv
// Single-packet ingress store in front of the header parser.
// Receives one packet as a byte stream, holds it in RAM and serves registered
// byte reads at hdr_addr until the parser releases it with pkt_done.
// Optional feature: define PKT_BUF_DROP_CNT_EN to count dropped oversize packets
// on drop_cnt; otherwise drop_cnt is tied to zero.
module pkt_buffer #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  in_ready,
  output logic                  pkt_valid,
  output logic [ADDR_WIDTH:0]   pkt_len,
  input  logic [ADDR_WIDTH-1:0] hdr_addr,
  output logic [DATA_WIDTH-1:0] hdr_data,
  input  logic                  pkt_done,
  output logic [15:0]           drop_cnt
);

  localparam int unsigned Depth = 2 ** ADDR_WIDTH;
  localparam int unsigned LenW  = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {StRecv, StHold, StDrop} state_e;

  logic [DATA_WIDTH-1:0] mem [Depth];

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LenW-1:0]       pkt_len_q, pkt_len_d;
  logic [DATA_WIDTH-1:0] hdr_data_q;
  logic                  mem_we;
  logic                  accept;

  // Ready is gated by reset so it drops immediately on an async reset.
  assign in_ready  = rst && (state_q != StHold);
  assign accept    = in_valid && in_ready;
  assign pkt_valid = (state_q == StHold);
  assign pkt_len   = pkt_len_q;
  assign hdr_data  = hdr_data_q;

  // Next-state logic: receive, hold for the parser, or discard an oversize packet.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    pkt_len_d = pkt_len_q;
    mem_we    = 1'b0;
    unique case (state_q)
      StRecv: begin
        if (accept) begin
          mem_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (in_last) begin
            // Full-depth packet gives wr_ptr==DEPTH-1, so length needs the extra bit.
            pkt_len_d = {1'b0, wr_ptr_q} + LenW'(1);
            state_d   = StHold;
          end else if (&wr_ptr_q) begin
            wr_ptr_d = '0;
            state_d  = StDrop;
          end
        end
      end
      StDrop: begin
        if (accept && in_last) begin
          state_d = StRecv;
        end
      end
      StHold: begin
        // A beat offered alongside pkt_done is not taken (in_ready is low here).
        if (pkt_done) begin
          wr_ptr_d = '0;
          state_d  = StRecv;
        end
      end
      default: begin
        state_d = StRecv;
      end
    endcase
  end

  // Control state with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StRecv;
      wr_ptr_q  <= '0;
      pkt_len_q <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      pkt_len_q <= pkt_len_d;
    end
  end

  // Packet RAM write port; contents are not reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= in_data;
    end
  end

  // Registered read port; reads outside a held packet return zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hdr_data_q <= '0;
    end else if (pkt_valid && ({1'b0, hdr_addr} < pkt_len_q)) begin
      hdr_data_q <= mem[hdr_addr];
    end else begin
      hdr_data_q <= '0;
    end
  end

`ifdef PKT_BUF_DROP_CNT_EN
  logic        drop_evt;
  logic [15:0] drop_cnt_q;

  assign drop_evt = (state_q == StRecv) && accept && !in_last && (&wr_ptr_q);
  assign drop_cnt = drop_cnt_q;

  // Saturating count of RECV->DROP transitions, cleared only by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt_q <= '0;
    end else if (drop_evt && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_q <= drop_cnt_q + 16'd1;
    end
  end
`else
  assign drop_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pkt_buffer.sv
// Directed bench for pkt_buffer with a 64-byte buffer.
module tb_pkt_buffer;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 6;
`ifdef PKT_BUF_DROP_CNT_EN
  localparam logic [15:0] ExpDrop = 16'd1;
`else
  localparam logic [15:0] ExpDrop = 16'd0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          in_ready;
  logic          pkt_valid;
  logic [AW:0]   pkt_len;
  logic [AW-1:0] hdr_addr;
  logic [DW-1:0] hdr_data;
  logic          pkt_done;
  logic [15:0]   drop_cnt;

  int tests = 0;
  int fails = 0;
  bit beat_bad;

  pkt_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_last  (in_last),
    .in_ready (in_ready),
    .pkt_valid(pkt_valid),
    .pkt_len  (pkt_len),
    .hdr_addr (hdr_addr),
    .hdr_data (hdr_data),
    .pkt_done (pkt_done),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sends len bytes base+i; beat_bad flags a beat not ready or pkt_valid seen early.
  task automatic send_pkt(input int len, input logic [7:0] base, input bit gap,
                          input int done_at);
    beat_bad = 1'b0;
    for (int i = 0; i < len; i++) begin
      int n;
      in_valid = 1'b1;
      in_data  = base + 8'(i);
      in_last  = (i == len - 1);
      n = 0;
      while (!in_ready && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      if (!in_ready || pkt_valid) beat_bad = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      if (gap) begin
        if (i == done_at) pkt_done = 1'b1;
        @(posedge clk); #1;
        pkt_done = 1'b0;
      end
    end
  endtask

  task automatic read_chk(input string tag, input logic [AW-1:0] a, input logic [7:0] exp);
    hdr_addr = a;
    @(posedge clk); #1;
    check(tag, 32'(hdr_data), 32'(exp));
  endtask

  task automatic release_pkt();
    pkt_done = 1'b1;
    @(posedge clk); #1;
    pkt_done = 1'b0;
  endtask

  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    hdr_addr = '0;
    pkt_done = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_pkt_valid", 32'(pkt_valid), 0);
    check("rst_pkt_len", 32'(pkt_len), 0);
    check("rst_hdr_data", 32'(hdr_data), 0);
    check("rst_drop_cnt", 32'(drop_cnt), 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("post_rst_ready", 32'(in_ready), 1);

    // 1: 14-byte packet
    send_pkt(14, 8'h00, 1'b0, -1);
    check("t1_beats", 32'(beat_bad), 0);
    check("t1_pkt_valid", 32'(pkt_valid), 1);
    check("t1_pkt_len", 32'(pkt_len), 14);
    read_chk("t1_rd5", 6'd5, 8'h05);

    // 2: read past end, ingress blocked while held
    read_chk("t2_rd20", 6'd20, 8'h00);
    in_valid = 1'b1; in_data = 8'hEE; in_last = 1'b1;
    check("t2_in_ready", 32'(in_ready), 0);
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    check("t2_still_valid", 32'(pkt_valid), 1);
    check("t2_len_same", 32'(pkt_len), 14);
    read_chk("t2_rd0", 6'd0, 8'h00);
    read_chk("t2_rd13", 6'd13, 8'h0D);
    read_chk("t2_rd14", 6'd14, 8'h00);

    // 3: release with a beat offered at the same time; beat taken only afterwards
    in_valid = 1'b1; in_data = 8'h40; in_last = 1'b0;
    pkt_done = 1'b1;
    @(posedge clk); #1;
    pkt_done = 1'b0;
    check("t3_pkt_valid", 32'(pkt_valid), 0);
    check("t3_in_ready", 32'(in_ready), 1);
    send_pkt(34, 8'h40, 1'b0, -1);
    check("t3_pkt_len", 32'(pkt_len), 34);
    read_chk("t3_rd14", 6'd14, 8'h4E);
    read_chk("t3_rd0", 6'd0, 8'h40);
    read_chk("t3_rd33", 6'd33, 8'h61);

    // 4: exact fit, then oversize drop, then normal packet
    release_pkt();
    send_pkt(64, 8'h80, 1'b0, -1);
    check("t4_fit_len", 32'(pkt_len), 64);
    read_chk("t4_rd63", 6'd63, 8'hBF);
    read_chk("t4_rd0", 6'd0, 8'h80);
    release_pkt();
    send_pkt(70, 8'h10, 1'b0, -1);
    check("t4_drop_beats", 32'(beat_bad), 0);
    check("t4_drop_valid", 32'(pkt_valid), 0);
    check("t4_drop_ready", 32'(in_ready), 1);
    check("t4_drop_cnt", 32'(drop_cnt), 32'(ExpDrop));
    check("t4_drop_len_kept", 32'(pkt_len), 64);
    send_pkt(20, 8'h20, 1'b0, -1);
    check("t4_after_valid", 32'(pkt_valid), 1);
    check("t4_after_len", 32'(pkt_len), 20);
    read_chk("t4_after_rd19", 6'd19, 8'h33);
    read_chk("t4_after_rd0", 6'd0, 8'h20);

    // 5: gapped valid with a spurious pkt_done mid-packet
    release_pkt();
    send_pkt(20, 8'h60, 1'b1, 9);
    check("t5_beats", 32'(beat_bad), 0);
    check("t5_pkt_len", 32'(pkt_len), 20);
    read_chk("t5_rd0", 6'd0, 8'h60);
    read_chk("t5_rd7", 6'd7, 8'h67);
    read_chk("t5_rd19", 6'd19, 8'h73);

    // 6: async reset mid-packet between clock edges
    release_pkt();
    send_pkt(0, 8'h00, 1'b0, -1);
    for (int i = 0; i < 7; i++) begin
      in_valid = 1'b1; in_data = 8'h50 + 8'(i); in_last = 1'b0;
      @(posedge clk); #1;
    end
    in_data = 8'h57;
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_ready", 32'(in_ready), 0);
    check("t6_rst_valid", 32'(pkt_valid), 0);
    check("t6_rst_len", 32'(pkt_len), 0);
    check("t6_rst_drop", 32'(drop_cnt), 0);
    in_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    send_pkt(14, 8'hA0, 1'b0, -1);
    check("t6_pkt_len", 32'(pkt_len), 14);
    read_chk("t6_rd13", 6'd13, 8'hAD);
    read_chk("t6_rd7", 6'd7, 8'hA7);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
